// File: rtl/switch_mcu_pkg.sv
// switch_mcu_pkg: shared defaults and helpers for the switch MCU register file.
package switch_mcu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/switch_mcu_regfile_rdport.sv
// switch_mcu_regfile_rdport: one read port with write bypass and registered data/busy.
module switch_mcu_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_old_data,
  input  logic              i_old_busy,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rbusy
);
  logic              w_hit;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  // a bypassed write also retires the producer, so busy drops on a hit
  assign w_hit = (BYPASS != 0) && i_wen && (i_waddr == i_raddr);
  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_data <= i_ren ? (w_hit ? i_wdata : i_old_data) : '0;
      r_busy <= i_ren && !w_hit && i_old_busy;
    end
  assign o_rdata = r_data;
  assign o_rbusy = r_busy;
endmodule

// File: rtl/switch_mcu_regfile_np.sv
// switch_mcu_regfile_np: parametrised multi-read-port register file with byte-enable
// writes, optional zero register, optional bypass and a pending scoreboard.
module switch_mcu_regfile_np
  import switch_mcu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_wen,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [DATA_W/8-1:0]      in_wbe,
  input  logic [NUM_RD-1:0]        in_ren,
  input  logic [NUM_RD*ADDR_W-1:0] in_raddr,
  output logic [NUM_RD*DATA_W-1:0] out_rdata,
  output logic [NUM_RD-1:0]        out_rbusy,
  input  logic                     in_rsv_en,
  input  logic [ADDR_W-1:0]        in_rsv_addr,
  output logic [2**ADDR_W-1:0]     out_pending
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pend_clr;
  logic [DATA_W-1:0] w_merged;
  logic              w_wr;
  logic              w_rsv;
  // the zero register swallows both writes and reservations
  assign w_wr  = in_wen && !(ZERO_REG != 0 && in_waddr == ADDR_W'(ZERO_ADDR));
  assign w_rsv = in_rsv_en && !(ZERO_REG != 0 && in_rsv_addr == ADDR_W'(ZERO_ADDR));
  assign w_pend_clr = r_pending & ~(w_wr ? DEPTH'(1) << in_waddr : '0);
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_be
    assign w_merged[b*8 +: 8] = merge_byte(r_mem[in_waddr][b*8 +: 8], in_wdata[b*8 +: 8], in_wbe[b]);
  end
  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) begin
      r_mem     <= '{default: '0};
      r_pending <= '0;
    end else begin
      if (w_wr) r_mem[in_waddr] <= w_merged;
      r_pending <= w_pend_clr | (w_rsv ? DEPTH'(1) << in_rsv_addr : '0);
    end
  assign out_pending = r_pending;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = in_raddr[p*ADDR_W +: ADDR_W];
    switch_mcu_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .i_ren     (in_ren[p]),
      .i_raddr   (w_ra),
      .i_wen     (w_wr),
      .i_waddr   (in_waddr),
      .i_wdata   (w_merged),
      .i_old_data(r_mem[w_ra]),
      .i_old_busy(r_pending[w_ra]),
      .o_rdata   (out_rdata[p*DATA_W +: DATA_W]),
      .o_rbusy   (out_rbusy[p])
    );
  end
endmodule

// File: tb/tb_switch_mcu_regfile_np.sv
// tb_switch_mcu_regfile_np: directed vectors on a 4-port bypass/zero-reg instance (A)
// and a 2-port no-bypass, no-zero-reg instance (B) sharing the same stimulus.
module tb_switch_mcu_regfile_np;
  logic         clk = 1'b0;
  logic         rst;
  logic         wen;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [3:0]   wbe;
  logic [3:0]   ren;
  logic [19:0]  raddr;
  logic         rsv;
  logic [4:0]   rsv_addr;
  logic [127:0] a_rdata;
  logic [3:0]   a_busy;
  logic [31:0]  a_pend;
  logic [63:0]  b_rdata;
  logic [1:0]   b_busy;
  logic [31:0]  b_pend;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_mcu_regfile_np #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .in_clk(clk), .in_rst(rst), .in_wen(wen), .in_waddr(waddr), .in_wdata(wdata), .in_wbe(wbe),
    .in_ren(ren), .in_raddr(raddr), .out_rdata(a_rdata), .out_rbusy(a_busy),
    .in_rsv_en(rsv), .in_rsv_addr(rsv_addr), .out_pending(a_pend));

  switch_mcu_regfile_np #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .in_clk(clk), .in_rst(rst), .in_wen(wen), .in_waddr(waddr), .in_wdata(wdata), .in_wbe(wbe),
    .in_ren(ren[1:0]), .in_raddr(raddr[9:0]), .out_rdata(b_rdata), .out_rbusy(b_busy),
    .in_rsv_en(rsv), .in_rsv_addr(rsv_addr), .out_pending(b_pend));

  typedef struct {
    logic wen; logic [4:0] waddr; logic [31:0] wdata; logic [3:0] wbe;
    logic rsv; logic [4:0] rsv_addr; logic [3:0] ren; logic [19:0] raddr;
    logic [127:0] ea; logic [3:0] eab; logic [31:0] ep; logic [63:0] eb; logic [1:0] ebb;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                              input logic r, input logic [4:0] ra_rsv, input logic [3:0] re, input logic [19:0] ra,
                              input logic [127:0] ea, input logic [3:0] eab, input logic [31:0] ep,
                              input logic [63:0] eb, input logic [1:0] ebb);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.wbe = be; v.rsv = r; v.rsv_addr = ra_rsv;
    v.ren = re; v.raddr = ra; v.ea = ea; v.eab = eab; v.ep = ep; v.eb = eb; v.ebb = ebb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic r, input logic [4:0] ra_rsv, input logic [3:0] re, input logic [19:0] ra);
    wen = w; waddr = wa; wdata = wd; wbe = be; rsv = r; rsv_addr = ra_rsv; ren = re; raddr = ra;
  endtask

  vec_t v[15];

  initial begin
    v[0]  = mk(1, 3, 32'hAABBCCDD, 4'hF, 0, 0, 4'b0000, 20'd0, 128'd0, 4'b0, 32'd0, 64'd0, 2'b0);
    v[1]  = mk(1, 3, 32'h11223344, 4'h5, 0, 0, 4'b0001, {15'd0, 5'd3}, {96'd0, 32'hAA22CC44}, 4'b0, 32'd0, {32'd0, 32'hAABBCCDD}, 2'b0);
    v[2]  = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd3}, {96'd0, 32'hAA22CC44}, 4'b0, 32'd0, {32'd0, 32'hAA22CC44}, 2'b0);
    v[3]  = mk(1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 4'b0001, 20'd0, 128'd0, 4'b0, 32'd0, 64'd0, 2'b0);
    v[4]  = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0011, 20'd0, 128'd0, 4'b0, 32'd0, {32'hFFFFFFFF, 32'hFFFFFFFF}, 2'b11);
    v[5]  = mk(1, 5, 32'h12345678, 4'hF, 0, 0, 4'b0011, {10'd0, 5'd5, 5'd5}, {64'd0, 32'h12345678, 32'h12345678}, 4'b0, 32'd0, 64'd0, 2'b0);
    v[6]  = mk(0, 0, 32'd0, 4'h0, 1, 9, 4'b0000, 20'd0, 128'd0, 4'b0, 32'h200, 64'd0, 2'b0);
    v[7]  = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd9}, 128'd0, 4'b0001, 32'h200, 64'd0, 2'b01);
    v[8]  = mk(1, 9, 32'hDEADBEEF, 4'hF, 0, 0, 4'b0011, {10'd0, 5'd9, 5'd9}, {64'd0, 32'hDEADBEEF, 32'hDEADBEEF}, 4'b0, 32'd0, 64'd0, 2'b11);
    v[9]  = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd9}, {96'd0, 32'hDEADBEEF}, 4'b0, 32'd0, {32'd0, 32'hDEADBEEF}, 2'b0);
    v[10] = mk(1, 9, 32'hCAFEF00D, 4'hF, 1, 9, 4'b0001, {15'd0, 5'd9}, {96'd0, 32'hCAFEF00D}, 4'b0, 32'h200, {32'd0, 32'hDEADBEEF}, 2'b0);
    v[11] = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd9}, {96'd0, 32'hCAFEF00D}, 4'b0001, 32'h200, {32'd0, 32'hCAFEF00D}, 2'b01);
    v[12] = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b1010, {5'd3, 5'd9, 5'd5, 5'd7}, {32'hAA22CC44, 32'd0, 32'h12345678, 32'd0}, 4'b0, 32'h200, {32'h12345678, 32'd0}, 2'b0);
    v[13] = mk(1, 9, 32'hFFFFFFFF, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd9}, {96'd0, 32'hCAFEF00D}, 4'b0, 32'd0, {32'd0, 32'hCAFEF00D}, 2'b01);
    v[14] = mk(0, 0, 32'd0, 4'h0, 0, 0, 4'b0001, {15'd0, 5'd9}, {96'd0, 32'hCAFEF00D}, 4'b0, 32'd0, {32'd0, 32'hCAFEF00D}, 2'b0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #2;
    chk("reset a_rdata", a_rdata, 128'd0);
    chk("reset a_busy", {124'd0, a_busy}, 128'd0);
    chk("reset a_pend", {96'd0, a_pend}, 128'd0);
    chk("reset b_rdata", {64'd0, b_rdata}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(v[i].wen, v[i].waddr, v[i].wdata, v[i].wbe, v[i].rsv, v[i].rsv_addr, v[i].ren, v[i].raddr);
      @(posedge clk); #1;
      chk($sformatf("v%0d a_rdata", i), a_rdata, v[i].ea);
      chk($sformatf("v%0d a_busy", i), {124'd0, a_busy}, {124'd0, v[i].eab});
      chk($sformatf("v%0d a_pend", i), {96'd0, a_pend}, {96'd0, v[i].ep});
      chk($sformatf("v%0d b_rdata", i), {64'd0, b_rdata}, {64'd0, v[i].eb});
      chk($sformatf("v%0d b_busy", i), {126'd0, b_busy}, {126'd0, v[i].ebb});
    end

    // asynchronous reset in the middle of traffic
    drive(1, 7, 32'h00000077, 4'hF, 1, 12, 4'b0001, {15'd0, 5'd3});
    @(posedge clk); #1;
    chk("pre-rst a_rdata", a_rdata, {96'd0, 32'hAA22CC44});
    chk("pre-rst a_pend", {96'd0, a_pend}, {96'd0, 32'h1000});
    #2 rst = 1'b0;
    #1;
    chk("async rst a_rdata", a_rdata, 128'd0);
    chk("async rst a_busy", {124'd0, a_busy}, 128'd0);
    chk("async rst a_pend", {96'd0, a_pend}, 128'd0);
    chk("async rst b_rdata", {64'd0, b_rdata}, 128'd0);
    chk("async rst b_pend", {96'd0, b_pend}, 128'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 4'b0011, {10'd0, 5'd7, 5'd7});
    @(posedge clk); #1;
    chk("post-rst a_rd7", a_rdata, 128'd0);
    chk("post-rst b_rd7", {64'd0, b_rdata}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/switch_mcu_regfile_np.md
# switch_mcu_regfile_np

Parametrised multi-read-port register file for the switch MCU core, succeeding the fixed 32x32, two-read-port register file. It adds configurable width, depth and read-port count, byte-enable writes, an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard for hazard detection. It sits between decode (reads and reservations) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1: register 0 reads 0, and writes and reservations to it are ignored
- BYPASS, 1, 1: a same-cycle write is forwarded to reads of the same address

- in_clk  in  1  clock, rising edge
- in_rst  in  1  reset, asynchronous, active-low
- in_wen  in  1  write enable
- in_waddr  in  ADDR_W  write address
- in_wdata  in  DATA_W  write data
- in_wbe  in  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k]
- in_ren  in  NUM_RD  per-port read enable
- in_raddr  in  NUM_RD*ADDR_W  port p address at [p*ADDR_W +: ADDR_W]
- out_rdata  out  NUM_RD*DATA_W  port p data at [p*DATA_W +: DATA_W], registered
- out_rbusy  out  NUM_RD  port p: read register has a pending producer, registered
- in_rsv_en  in  1  reserve (mark pending) request
- in_rsv_addr  in  ADDR_W  register to reserve
- out_pending  out  DEPTH  scoreboard vector, registered

## Operation
- Reset: all registers 0, out_rdata 0, out_rbusy 0, out_pending 0.
- Write: on an edge with in_wen=1, only the enabled bytes of reg[in_waddr] update; other bytes hold. With in_wen=1 and in_wbe=0, data is unchanged but the pending bit still clears.
- ZERO_REG=1: writes to address 0 are dropped, pending[0] stays 0, and reads of address 0 return 0 with busy 0.
- Read: each port is independent. With in_ren[p]=1, out_rdata[p] captures reg[raddr_p]. With in_ren[p]=0, out_rdata[p] and out_rbusy[p] go to 0 at the next edge.
- Bypass (BYPASS=1): if in_wen=1 and waddr==raddr_p in the same cycle, the captured value is the byte-merged new value and the captured busy is 0.
- Bypass off (BYPASS=0): the same case captures the old value and old busy.
- Scoreboard, per edge:
  - in_rsv_en sets pending[rsv_addr].
  - in_wen clears pending[waddr].
  - Reserve and write to the same address in one cycle: the set wins (a new producer has issued).
- out_rbusy[p] is pending[raddr_p] after applying the same-cycle write clear (when BYPASS=1), before the same-cycle reservation set.
- Asynchronous reset mid-operation clears everything immediately. Requests in flight are lost.

## Timing
- Write to storage: 1 cycle.
- Read latency: 1 cycle (address in cycle n, data and busy valid after edge n+1).
- Read-after-write with BYPASS=1: 0 extra cycles. With BYPASS=0: a read issued in the write cycle sees old data, and a read in the next cycle sees new data.
- out_pending reflects reservations and clears 1 cycle after the request.
- No handshake stalls: every port accepts a request every cycle.

## Structure
- Shared package switch_mcu_pkg: DATA_W/ADDR_W defaults, byte-merge function, zero-register address constant.
- Sub-module switch_mcu_regfile_rdport, instantiated NUM_RD times via generate: address compare, bypass mux, output registers.
- Storage, write merge and scoreboard live in the top level.

## Test plan
- Reset: assert in_rst=0 mid-traffic -> all out_rdata=0, out_rbusy=0, out_pending=0 immediately; a post-reset read of reg 7 returns 0.
- Byte enables: write reg 3=0xAABBCCDD with be=0xF, then 0x11223344 with be=0x5 -> read returns 0xAA22CC44.
- Zero register: write reg 0=0xFFFFFFFF and reserve reg 0 -> read returns 0, busy 0, pending[0]=0; with ZERO_REG=0 the read returns 0xFFFFFFFF.
- Bypass: same-cycle write reg 5=0x12345678 and read reg 5 on both ports -> both return 0x12345678 after 1 cycle; with BYPASS=0 both return the old value.
- Scoreboard: reserve reg 9 -> pending[9]=1 and a read of 9 has busy=1; write reg 9 -> busy clears. Simultaneous reserve and write of reg 9 -> pending[9] stays 1.
- Disabled port and NUM_RD=4: ren=4'b1010 with distinct addresses -> ports 1 and 3 return correct data, ports 0 and 2 return 0.
